// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite pixel fetch block.
//   COLOUR_W        palette colour width
//   ELEMENT_W       sprite memory element (bank) select width
//   COORD_W/SIZE_W  pixel coordinate and sprite side-length widths
//   TRANSPARENT_DEF default see-through colour
//   slot_t          one sprite placement entry
//   state_t         fetch FSM states
package sprite_pkg;
  localparam int COLOUR_W  = 12;
  localparam int ELEMENT_W = 3;
  localparam int COORD_W   = 10;
  localparam int SIZE_W    = 6;

  localparam logic [COLOUR_W-1:0] TRANSPARENT_DEF = 12'h000;

  typedef struct packed {
    logic                 en;
    logic [ELEMENT_W-1:0] element;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [SIZE_W-1:0]    size;
  } slot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/sprite_hit_test.sv
// sprite_hit_test: combinational bounding-box test and linear texel address
// for one sprite placement.
//   slot_i  placement entry under test
//   px_i    pixel x
//   py_i    pixel y
//   hit_o   pixel lies inside an enabled sprite
//   addr_o  (py-y)*size + (px-x), truncated to ADDR_W (meaningful only on hit)
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  slot_t              slot_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);
  logic [COORD_W:0]     x_end, y_end;
  logic [COORD_W-1:0]   dx, dy;
  logic [2*COORD_W-1:0] lin;
  logic                 unused_hi;

  // One extra bit so a sprite near the right/bottom edge cannot wrap to 0
  // and produce a false hit on small coordinates.
  assign x_end = {1'b0, slot_i.x} + {{(COORD_W+1-SIZE_W){1'b0}}, slot_i.size};
  assign y_end = {1'b0, slot_i.y} + {{(COORD_W+1-SIZE_W){1'b0}}, slot_i.size};

  assign hit_o = slot_i.en &&
                 (px_i >= slot_i.x) && ({1'b0, px_i} < x_end) &&
                 (py_i >= slot_i.y) && ({1'b0, py_i} < y_end);

  assign dx  = px_i - slot_i.x;
  assign dy  = py_i - slot_i.y;
  assign lin = ({{COORD_W{1'b0}}, dy} * {{(2*COORD_W-SIZE_W){1'b0}}, slot_i.size})
             + {{COORD_W{1'b0}}, dx};

  assign addr_o    = lin[ADDR_W-1:0];
  assign unused_hi = ^lin[2*COORD_W-1:ADDR_W];
endmodule

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: per-pixel priority scan of the sprite placement table,
// one read per hit slot to the sprite memory bank, final colour out.
// Optional feature macro: SPRITE_FETCH_TRANSPARENCY_EN -- when defined, a
// returned TRANSPARENT colour continues the scan with the next slot.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   pix_valid_i, pix_x_i, pix_y_i  pixel request (ignored while busy_o)
//   bg_colour_i                    fallback colour
//   busy_o                         fetch in progress
//   colour_out_o, colour_valid_o   result and its one-cycle strobe
//   slot_we_i ... slot_size_i      placement table write port
//   mem_read_enable_o, mem_element_o, mem_address_o   read request
//   mem_dataout_i, mem_ready_i     read response
//   err_timeout_o                  sticky memory timeout flag
// Element select width is sprite_pkg::ELEMENT_W.
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int                  NUM_SLOTS   = 4,
  parameter int                  ADDR_W      = 10,
  parameter int                  TIMEOUT     = 15,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_DEF,
  localparam int                 IDX_W       = $clog2(NUM_SLOTS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pix_valid_i,
  input  logic [COORD_W-1:0]   pix_x_i,
  input  logic [COORD_W-1:0]   pix_y_i,
  input  logic [COLOUR_W-1:0]  bg_colour_i,
  output logic                 busy_o,
  output logic [COLOUR_W-1:0]  colour_out_o,
  output logic                 colour_valid_o,
  input  logic                 slot_we_i,
  input  logic [IDX_W-1:0]     slot_idx_i,
  input  logic                 slot_en_i,
  input  logic [ELEMENT_W-1:0] slot_element_i,
  input  logic [COORD_W-1:0]   slot_x_i,
  input  logic [COORD_W-1:0]   slot_y_i,
  input  logic [SIZE_W-1:0]    slot_size_i,
  output logic                 mem_read_enable_o,
  output logic [ELEMENT_W-1:0] mem_element_o,
  output logic [ADDR_W-1:0]    mem_address_o,
  input  logic [COLOUR_W-1:0]  mem_dataout_i,
  input  logic                 mem_ready_i,
  output logic                 err_timeout_o
);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]    IDX_END  = (IDX_W+1)'(NUM_SLOTS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  slot_t                slot_q [NUM_SLOTS];
  state_t               state_q;
  // One bit wider than a slot index: IDX_END marks "all slots exhausted",
  // which costs one extra SCAN cycle before DONE on the fallback path.
  logic [IDX_W:0]       idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [COORD_W-1:0]   px_q, py_q;
  logic [COLOUR_W-1:0]  bg_q, colour_q;
  logic                 busy_q, colour_valid_q, rd_en_q, err_q;
  logic [ELEMENT_W-1:0] elem_q;
  logic [ADDR_W-1:0]    addr_q;

  slot_t                cur_slot;
  logic                 cur_hit;
  logic [ADDR_W-1:0]    cur_addr;

  assign cur_slot = slot_q[idx_q[IDX_W-1:0]];

  sprite_hit_test #(.ADDR_W(ADDR_W)) u_hit (
    .slot_i (cur_slot),
    .px_i   (px_q),
    .py_i   (py_q),
    .hit_o  (cur_hit),
    .addr_o (cur_addr)
  );

`ifndef SPRITE_FETCH_TRANSPARENCY_EN
  logic unused_transparent;
  assign unused_transparent = ^TRANSPARENT;
`endif

  // Placement table: writes land next cycle, so a running scan picks up
  // whatever is in the table when it reaches each slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= '0;
    end else if (slot_we_i) begin
      slot_q[slot_idx_i] <= '{en: slot_en_i, element: slot_element_i,
                              x: slot_x_i, y: slot_y_i, size: slot_size_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      px_q           <= '0;
      py_q           <= '0;
      bg_q           <= '0;
      colour_q       <= '0;
      busy_q         <= 1'b0;
      colour_valid_q <= 1'b0;
      rd_en_q        <= 1'b0;
      err_q          <= 1'b0;
      elem_q         <= '0;
      addr_q         <= '0;
    end else begin
      colour_valid_q <= 1'b0;
      rd_en_q        <= 1'b0;
      case (state_q)
        ST_IDLE: if (pix_valid_i) begin
          px_q    <= pix_x_i;
          py_q    <= pix_y_i;
          bg_q    <= bg_colour_i;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (idx_q == IDX_END) begin
            colour_q       <= bg_q;
            colour_valid_q <= 1'b1;
            state_q        <= ST_DONE;
          end else if (cur_hit) begin
            rd_en_q <= 1'b1;
            addr_q  <= cur_addr;
            elem_q  <= cur_slot.element;
            state_q <= ST_REQ;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_REQ: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ready_i) begin
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
            if (mem_dataout_i == TRANSPARENT) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_SCAN;
            end else begin
              colour_q       <= mem_dataout_i;
              colour_valid_q <= 1'b1;
              state_q        <= ST_DONE;
            end
`else
            colour_q       <= mem_dataout_i;
            colour_valid_q <= 1'b1;
            state_q        <= ST_DONE;
`endif
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_SCAN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign colour_out_o      = colour_q;
  assign colour_valid_o    = colour_valid_q;
  assign mem_read_enable_o = rd_en_q;
  assign mem_element_o     = elem_q;
  assign mem_address_o     = addr_q;
  assign err_timeout_o     = err_q;
endmodule
